// File: rtl/nfu_2_reduce_acc.sv
// nfu_2_reduce_acc: Tn pipelined SUM/MAX/MIN reduction trees over Ti
// NFU-1 products, followed by a per-tree group accumulator.
// Ports: clk, rst_n (sync, active-low), i_valid/i_stall/i_first/i_last,
//   i_op (0 SUM, 1 MAX, 2 MIN, 3 SUM), i_use_nbout, i_nfu1_out (Tn*Ti*N),
//   i_nbout (Tn*N seeds), o_valid (result pulse), o_nfu2_out (Tn*N).
module nfu_2_reduce_acc #(
    parameter int N             = 16,
    parameter int Tn            = 16,
    parameter int Ti            = 16,
    parameter int LVL_PER_STAGE = 2,
    parameter int G             = 8,
    parameter bit SAT           = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_stall,
    input  logic              i_first,
    input  logic              i_last,
    input  logic [1:0]        i_op,
    input  logic              i_use_nbout,
    input  logic [N*Tn*Ti-1:0] i_nfu1_out,
    input  logic [N*Tn-1:0]   i_nbout,
    output logic              o_valid,
    output logic [N*Tn-1:0]   o_nfu2_out
);

    localparam int LEVELS = $clog2(Ti);
    localparam int W      = N + LEVELS + G;

    localparam logic signed [W-1:0] ID_MAX =
        {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] ID_MIN =
        {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] NMAX =
        {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [W-1:0] NMIN =
        {{(W-N+1){1'b1}}, {(N-1){1'b0}}};

    typedef struct packed {
        logic            valid;
        logic            first;
        logic            last;
        logic [1:0]      op;
        logic            use_nb;
        logic [N*Tn-1:0] nbout;
    } ctl_t;

    function automatic logic signed [W-1:0] f_op(
        input logic [1:0]          op,
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        logic signed [W-1:0] r;
        unique case (1'b1)
            (op == 2'd1): r = (a > b) ? a : b;
            (op == 2'd2): r = (a < b) ? a : b;
            default:      r = a + b;
        endcase
        return r;
    endfunction

    function automatic logic signed [W-1:0] ident(
        input logic [1:0] op
    );
        logic signed [W-1:0] r;
        unique case (1'b1)
            (op == 2'd1): r = ID_MAX;
            (op == 2'd2): r = ID_MIN;
            default:      r = '0;
        endcase
        return r;
    endfunction

    function automatic logic signed [W-1:0] sext(
        input logic [N-1:0] x
    );
        return {{(W-N){x[N-1]}}, x};
    endfunction

    // Level l holds Ti>>l nodes per tree; a register sits after every
    // LVL_PER_STAGE levels and always after the root level.
    for (genvar l = 0; l <= LEVELS; l++) begin : lv
        localparam int M = Ti >> l;
        logic signed [W-1:0] v [Tn][M];
        ctl_t                c;

        if (l == 0) begin : g_in
            assign c = {i_valid, i_first, i_last, i_op,
                        i_use_nbout, i_nbout};
            for (genvar t = 0; t < Tn; t++) begin : g_t
                for (genvar j = 0; j < M; j++) begin : g_j
                    assign v[t][j] =
                        sext(i_nfu1_out[(t*Ti+j)*N +: N]);
                end
            end
        end else begin : g_node
            logic signed [W-1:0] s [Tn][M];
            for (genvar t = 0; t < Tn; t++) begin : g_t
                for (genvar k = 0; k < M; k++) begin : g_k
                    assign s[t][k] = f_op(lv[l-1].c.op,
                                          lv[l-1].v[t][2*k],
                                          lv[l-1].v[t][2*k+1]);
                end
            end
            if ((l % LVL_PER_STAGE == 0) || (l == LEVELS)) begin : g_reg
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        c <= '0;
                        v <= '{default: '0};
                    end else if (!i_stall) begin
                        c <= lv[l-1].c;
                        v <= s;
                    end
                end
            end else begin : g_comb
                assign c = lv[l-1].c;
                assign v = s;
            end
        end
    end

    ctl_t fin;
    assign fin = lv[LEVELS].c;

    for (genvar t = 0; t < Tn; t++) begin : g_acc
        logic signed [W-1:0] acc;
        logic signed [W-1:0] base;
        logic signed [W-1:0] nx;
        logic [N-1:0]        red;
        logic [N-1:0]        q;

        always_comb begin
            base = acc;
            if (fin.first) begin
                base = fin.use_nb ? sext(fin.nbout[t*N +: N])
                                  : ident(fin.op);
            end
            nx  = f_op(fin.op, base, lv[LEVELS].v[t][0]);
            red = nx[N-1:0];
            // MAX/MIN results are always in N-bit range.
            if (SAT && fin.op != 2'd1 && fin.op != 2'd2) begin
                if (nx > NMAX)      red = NMAX[N-1:0];
                else if (nx < NMIN) red = NMIN[N-1:0];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc <= '0;
                q   <= '0;
            end else if (!i_stall && fin.valid) begin
                acc <= nx;
                if (fin.last) q <= red;
            end
        end

        assign o_nfu2_out[t*N +: N] = q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)        o_valid <= 1'b0;
        else if (!i_stall) o_valid <= fin.valid & fin.last;
    end

endmodule
